// File: rtl/sonar_scan_if.sv
// Handshake bundle between the sonar scan controller and its surroundings:
// run enable, measurement/serial completion strobes and the controller outputs.
interface sonar_scan_if;
    logic       ligar;
    logic       sensor_pronto;
    logic       serial_pronto;
    logic       medicao;
    logic       transmissao;
    logic [2:0] sel;
    logic [2:0] posicao;
    logic       erro_timeout;
    logic       fim_ciclo;
    logic [3:0] db_estado;

    modport master (
        output ligar, sensor_pronto, serial_pronto,
        input  medicao, transmissao, sel, posicao, erro_timeout, fim_ciclo, db_estado
    );

    modport slave (
        input  ligar, sensor_pronto, serial_pronto,
        output medicao, transmissao, sel, posicao, erro_timeout, fim_ciclo, db_estado
    );
endinterface

// File: rtl/sonar_scan_ctrl.sv
// Sonar scan sequencer: steps the servo through a 0..7..1 sweep, waits for the
// servo to settle, fires a measurement, then streams N_CHARS characters to the
// serial transmitter before moving on to the next position.
//
// state          | meaning
// ---------------+------------------------------------------------------
// INICIAL        | idle at position 0, waiting for ligar
// POSICIONA      | servo settling for SETTLE_CYCLES clocks
// MEDE           | one-cycle measurement start pulse
// AGUARDA_MEDIDA | waiting for sensor_pronto or the measurement timeout
// TRANSMITE      | one-cycle character transmit start pulse
// AGUARDA_SERIAL | waiting (unbounded) for serial_pronto
// PROXIMO_CHAR   | advance character index or finish the position
// PROXIMO_POS    | advance the sweep; sample ligar
module sonar_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int N_CHARS        = 6
) (
    input logic        clock,
    input logic        reset,
    sonar_scan_if.slave bus
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    // Timeout fires when the counter is about to reach TIMEOUT_CYCLES-1, so the
    // medicao cycle plus the wait cycles add up to TIMEOUT_CYCLES clocks.
    localparam logic [TW:0]   TMO_LAST    = (TW + 1)'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    SEL_LAST    = 3'(N_CHARS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        POSICIONA      = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_SERIAL = 4'd5,
        PROXIMO_CHAR   = 4'd6,
        PROXIMO_POS    = 4'd7
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    posicao_q, posicao_d;
    logic          dir_up_q, dir_up_d;
    logic          erro_q, erro_d;
    logic          medicao_q, medicao_d;
    logic          transmissao_q, transmissao_d;
    logic          fim_q, fim_d;

    logic [TW:0]   tmo_next;
    logic          tmo_hit;
    logic          settle_done;

    assign tmo_next    = {1'b0, tmo_cnt_q} + {{TW{1'b0}}, 1'b1};
    assign tmo_hit     = (tmo_next >= TMO_LAST);
    assign settle_done = (settle_cnt_q >= SETTLE_LAST);

    // Next-state, counters, sweep position and registered pulse outputs.
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = '0;
        tmo_cnt_d     = tmo_cnt_q;
        sel_d         = sel_q;
        posicao_d     = posicao_q;
        dir_up_d      = dir_up_q;
        erro_d        = erro_q;
        fim_d         = 1'b0;

        case (state_q)
            INICIAL: begin
                posicao_d = 3'd0;
                dir_up_d  = 1'b1;
                sel_d     = 3'd0;
                if (bus.ligar) state_d = POSICIONA;
            end
            POSICIONA: begin
                if (settle_done) begin
                    state_d   = MEDE;
                    // Clear the error flag on entry so it is already low
                    // during the medicao pulse of the new position.
                    erro_d    = 1'b0;
                    tmo_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            MEDE: begin
                erro_d    = 1'b0;
                tmo_cnt_d = '0;
                state_d   = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                if (bus.sensor_pronto) begin
                    state_d = TRANSMITE;
                    sel_d   = 3'd0;
                end else if (tmo_hit) begin
                    erro_d  = 1'b1;
                    state_d = TRANSMITE;
                    sel_d   = 3'd0;
                end else begin
                    tmo_cnt_d = tmo_next[TW-1:0];
                end
            end
            TRANSMITE: begin
                state_d = AGUARDA_SERIAL;
            end
            AGUARDA_SERIAL: begin
                if (bus.serial_pronto) state_d = PROXIMO_CHAR;
            end
            PROXIMO_CHAR: begin
                if (sel_q < SEL_LAST) begin
                    sel_d   = sel_q + 3'd1;
                    state_d = TRANSMITE;
                end else begin
                    state_d = PROXIMO_POS;
                    // fim_ciclo is high during the PROXIMO_POS cycle of the 1->0 step.
                    fim_d   = !dir_up_q && (posicao_q == 3'd1);
                end
            end
            PROXIMO_POS: begin
                if (dir_up_q) begin
                    if (posicao_q == 3'd7) begin
                        dir_up_d  = 1'b0;
                        posicao_d = 3'd6;
                    end else begin
                        posicao_d = posicao_q + 3'd1;
                    end
                end else begin
                    if (posicao_q <= 3'd1) begin
                        posicao_d = 3'd0;
                        dir_up_d  = 1'b1;
                    end else begin
                        posicao_d = posicao_q - 3'd1;
                    end
                end
                state_d = bus.ligar ? POSICIONA : INICIAL;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase

        medicao_d     = (state_d == MEDE);
        transmissao_d = (state_d == TRANSMITE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= INICIAL;
            settle_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            sel_q         <= 3'd0;
            posicao_q     <= 3'd0;
            dir_up_q      <= 1'b1;
            erro_q        <= 1'b0;
            medicao_q     <= 1'b0;
            transmissao_q <= 1'b0;
            fim_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            sel_q         <= sel_d;
            posicao_q     <= posicao_d;
            dir_up_q      <= dir_up_d;
            erro_q        <= erro_d;
            medicao_q     <= medicao_d;
            transmissao_q <= transmissao_d;
            fim_q         <= fim_d;
        end
    end

    assign bus.medicao      = medicao_q;
    assign bus.transmissao  = transmissao_q;
    assign bus.sel          = sel_q;
    assign bus.posicao      = posicao_q;
    assign bus.erro_timeout = erro_q;
    assign bus.fim_ciclo    = fim_q;
    assign bus.db_estado    = state_q;

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Bench for sonar_scan_ctrl: responders model the sensor and serial TX, a
// monitor keeps its own sweep model and a queue of expected characters.
module tb_sonar_scan_ctrl;

    localparam int SETTLE = 4;
    localparam int TMO    = 20;
    localparam int NC     = 6;

    typedef struct packed {
        logic [2:0] pos;
        logic [2:0] sel;
        logic       erro;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ligar = 1'b0;
    logic sen_auto = 1'b0;
    logic ser_auto = 1'b0;
    logic ser_man  = 1'b0;

    int   total = 0;
    int   bad   = 0;

    int   sensor_delay = 10;      // 0 means the sensor never answers
    bit   auto_ser_en  = 1'b1;
    int   epoch        = 0;       // bumped by tests when the DUT returns to idle

    exp_t sbq[$];
    int   seen_epoch   = -1;
    int   meas_count   = 0;
    int   fim_count    = 0;
    int   tx_pos_count = 0;
    logic [2:0] exp_pos = 3'd0;
    bit   exp_up = 1'b1;
    logic prev_med = 1'b0, prev_tx = 1'b0, prev_fim = 1'b0;

    always #5 clock = ~clock;

    sonar_scan_if bus();

    assign bus.ligar         = ligar;
    assign bus.sensor_pronto = sen_auto;
    assign bus.serial_pronto = ser_auto | ser_man;

    sonar_scan_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .N_CHARS       (NC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Monitor: sweep model, scoreboard push on medicao, pop on transmissao.
    always @(negedge clock) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            sbq.delete();
            exp_pos    = 3'd0;
            exp_up     = 1'b1;
            meas_count = 0;
            fim_count  = 0;
        end
        if (bus.medicao) begin
            total++;
            if (prev_med !== 1'b0) begin
                bad++; $display("FAIL medicao_width: medicao high two cycles in a row");
            end
            total++;
            if (bus.posicao !== exp_pos) begin
                bad++; $display("FAIL medicao_pos: got=%0d want=%0d", bus.posicao, exp_pos);
            end
            total++;
            if (bus.erro_timeout !== 1'b0) begin
                bad++; $display("FAIL erro_at_medicao: got=%0b want=0", bus.erro_timeout);
            end
            for (int i = 0; i < NC; i++)
                sbq.push_back('{pos: exp_pos, sel: 3'(i), erro: (sensor_delay == 0)});
            meas_count++;
            tx_pos_count = 0;
            if (exp_up) begin
                if (exp_pos == 3'd7) begin exp_up = 1'b0; exp_pos = 3'd6; end
                else exp_pos = exp_pos + 3'd1;
            end else begin
                if (exp_pos == 3'd1) begin exp_up = 1'b1; exp_pos = 3'd0; end
                else exp_pos = exp_pos - 3'd1;
            end
        end
        if (bus.transmissao) begin : tx_chk
            exp_t e;
            total++;
            if (prev_tx !== 1'b0) begin
                bad++; $display("FAIL tx_width: transmissao high two cycles in a row");
            end
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: pos=%0d sel=%0d, none expected", bus.posicao, bus.sel);
            end else begin
                e = sbq.pop_front();
                if ({bus.posicao, bus.sel, bus.erro_timeout} !== e) begin
                    bad++;
                    $display("FAIL tx_char: got pos=%0d sel=%0d erro=%0b want pos=%0d sel=%0d erro=%0b",
                             bus.posicao, bus.sel, bus.erro_timeout, e.pos, e.sel, e.erro);
                end
            end
            tx_pos_count++;
        end
        if (bus.fim_ciclo) begin
            total++;
            if (prev_fim !== 1'b0) begin
                bad++; $display("FAIL fim_width: fim_ciclo high two cycles in a row");
            end
            total++;
            if (bus.posicao !== 3'd1) begin
                bad++; $display("FAIL fim_pos: fim_ciclo at posicao=%0d want=1", bus.posicao);
            end
            fim_count++;
        end
        prev_med = bus.medicao;
        prev_tx  = bus.transmissao;
        prev_fim = bus.fim_ciclo;
    end

    // Sensor model: answers sensor_delay clocks after medicao, or checks the timeout.
    always @(negedge clock) begin
        if (bus.medicao) begin
            if (sensor_delay > 0) begin
                repeat (sensor_delay - 1) @(negedge clock);
                sen_auto = 1'b1;
                @(negedge clock);
                sen_auto = 1'b0;
            end else begin
                repeat (TMO - 1) @(negedge clock);
                total++;
                if (bus.erro_timeout !== 1'b0) begin
                    bad++; $display("FAIL erro_early: got=%0b want=0 at %0d clocks", bus.erro_timeout, TMO - 1);
                end
                @(negedge clock);
                total++;
                if (bus.erro_timeout !== 1'b1) begin
                    bad++; $display("FAIL erro_set: got=%0b want=1 at %0d clocks", bus.erro_timeout, TMO);
                end
            end
        end
    end

    // Serial model: character done 5 clocks after each transmissao; sel must hold.
    always @(negedge clock) begin
        if (bus.transmissao && auto_ser_en) begin : srv
            logic [2:0] s;
            s = bus.sel;
            repeat (4) @(negedge clock);
            total++;
            if (bus.sel !== s) begin
                bad++; $display("FAIL sel_stable: got=%0d want=%0d", bus.sel, s);
            end
            ser_auto = 1'b1;
            @(negedge clock);
            ser_auto = 1'b0;
        end
    end

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (bus.db_estado !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (bus.db_estado !== s) begin
            bad++; $display("FAIL %s: db_estado=%0d want=%0d after %0d clocks", name, bus.db_estado, s, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ligar = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (bus.db_estado !== 4'd0)   begin bad++; $display("FAIL rst_state: got=%0d want=0", bus.db_estado); end
        total++; if (bus.medicao !== 1'b0)     begin bad++; $display("FAIL rst_medicao: got=%0b want=0", bus.medicao); end
        total++; if (bus.transmissao !== 1'b0) begin bad++; $display("FAIL rst_tx: got=%0b want=0", bus.transmissao); end
        total++; if (bus.sel !== 3'd0)         begin bad++; $display("FAIL rst_sel: got=%0d want=0", bus.sel); end
        total++; if (bus.posicao !== 3'd0)     begin bad++; $display("FAIL rst_pos: got=%0d want=0", bus.posicao); end
        total++; if (bus.erro_timeout !== 1'b0) begin bad++; $display("FAIL rst_erro: got=%0b want=0", bus.erro_timeout); end
        total++; if (bus.fim_ciclo !== 1'b0)   begin bad++; $display("FAIL rst_fim: got=%0b want=0", bus.fim_ciclo); end
        reset = 1'b0;
        epoch++;
        @(negedge clock);
        total++; if (bus.db_estado !== 4'd0)   begin bad++; $display("FAIL idle_state: got=%0d want=0", bus.db_estado); end
    endtask

    // ligar sampled at the next edge; 4 settle clocks; medicao on the 5th negedge.
    task automatic test_first_measure();
        sensor_delay = 10;
        ligar = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            total++;
            if (bus.medicao !== 1'b0) begin
                bad++; $display("FAIL first_med_early: medicao=1 at clock %0d", n);
            end
            if (n == 1) begin
                total++;
                if (bus.db_estado !== 4'd1) begin
                    bad++; $display("FAIL first_posiciona: got=%0d want=1", bus.db_estado);
                end
            end
        end
        @(negedge clock);
        total++;
        if (bus.medicao !== 1'b1) begin
            bad++; $display("FAIL first_med_time: medicao=%0b want=1 at clock 5", bus.medicao);
        end
        wait_state(4'd7, 200, "first_done");
        total++; if (tx_pos_count !== NC) begin bad++; $display("FAIL first_chars: got=%0d want=%0d", tx_pos_count, NC); end
        total++; if (sbq.size() != 0)     begin bad++; $display("FAIL first_pending: got=%0d want=0", sbq.size()); end
        @(negedge clock);
        total++; if (bus.posicao !== 3'd1) begin bad++; $display("FAIL first_next_pos: got=%0d want=1", bus.posicao); end
    endtask

    task automatic test_timeout();
        sensor_delay = 0;
        wait_state(4'd7, 300, "timeout_done");
        total++; if (tx_pos_count !== NC) begin bad++; $display("FAIL timeout_chars: got=%0d want=%0d", tx_pos_count, NC); end
        total++; if (sbq.size() != 0)     begin bad++; $display("FAIL timeout_pending: got=%0d want=0", sbq.size()); end
        sensor_delay = 10;
    endtask

    task automatic test_sweep();
        int n = 0;
        while (fim_count == 0 && n < 3000) begin @(negedge clock); n++; end
        total++; if (fim_count != 1)   begin bad++; $display("FAIL sweep_fim: got=%0d want=1", fim_count); end
        total++; if (meas_count != 14) begin bad++; $display("FAIL sweep_len: got=%0d want=14", meas_count); end
        n = 0;
        while (meas_count < 15 && n < 300) begin @(negedge clock); n++; end
        total++; if (meas_count != 15) begin bad++; $display("FAIL sweep_restart: meas=%0d want=15", meas_count); end
        total++; if (fim_count != 1)   begin bad++; $display("FAIL sweep_fim_once: got=%0d want=1", fim_count); end
    endtask

    task automatic test_ligar_drop();
        int n = 0;
        int mc;
        while (!(bus.db_estado === 4'd5 && bus.sel === 3'd2) && n < 500) begin @(negedge clock); n++; end
        total++;
        if (!(bus.db_estado === 4'd5 && bus.sel === 3'd2)) begin
            bad++; $display("FAIL drop_reach: state=%0d sel=%0d want 5/2", bus.db_estado, bus.sel);
        end
        ligar = 1'b0;
        wait_state(4'd0, 300, "drop_idle");
        total++; if (tx_pos_count !== NC) begin bad++; $display("FAIL drop_chars: got=%0d want=%0d", tx_pos_count, NC); end
        total++; if (sbq.size() != 0)     begin bad++; $display("FAIL drop_pending: got=%0d want=0", sbq.size()); end
        @(negedge clock);
        total++; if (bus.posicao !== 3'd0) begin bad++; $display("FAIL drop_pos: got=%0d want=0", bus.posicao); end
        epoch++;
        @(negedge clock);
        mc = meas_count;
        repeat (60) @(negedge clock);
        total++; if (meas_count != mc)     begin bad++; $display("FAIL drop_no_med: got=%0d want=%0d", meas_count, mc); end
        total++; if (bus.db_estado !== 4'd0) begin bad++; $display("FAIL drop_stay: got=%0d want=0", bus.db_estado); end
    endtask

    task automatic test_reset_mid();
        auto_ser_en = 1'b0;
        ligar = 1'b1;
        wait_state(4'd5, 200, "mid_reach");
        reset   = 1'b1;
        ser_man = 1'b1;
        @(negedge clock);
        total++; if (bus.db_estado !== 4'd0)   begin bad++; $display("FAIL mid_state: got=%0d want=0", bus.db_estado); end
        total++; if (bus.sel !== 3'd0)         begin bad++; $display("FAIL mid_sel: got=%0d want=0", bus.sel); end
        total++; if (bus.transmissao !== 1'b0) begin bad++; $display("FAIL mid_tx: got=%0b want=0", bus.transmissao); end
        total++; if (bus.posicao !== 3'd0)     begin bad++; $display("FAIL mid_pos: got=%0d want=0", bus.posicao); end
        reset   = 1'b0;
        ser_man = 1'b0;
        ligar   = 1'b0;
        epoch++;
        repeat (20) @(negedge clock);
        total++; if (bus.db_estado !== 4'd0)   begin bad++; $display("FAIL mid_idle: got=%0d want=0", bus.db_estado); end
        auto_ser_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_measure();
        test_timeout();
        test_sweep();
        test_ligar_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
